// File: rtl/hwpe_ctrl_context_scheduler.sv
// Context scheduler for an HWPE controller: an offload lock guards the
// programming of one job context at a time, committed jobs are queued in a
// ring of N_CONTEXT contexts, and a small FSM starts and retires them in order.
module hwpe_ctrl_context_scheduler #(
    parameter  int unsigned N_CONTEXT    = 2,
    parameter  int unsigned ID_WIDTH     = 16,
    parameter  int unsigned LOCK_TIMEOUT = 0,
    localparam int unsigned CW           = $clog2(N_CONTEXT)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                testset_i,
    input  logic [ID_WIDTH-1:0] testset_src_i,
    input  logic                trigger_i,
    input  logic [ID_WIDTH-1:0] trigger_src_i,
    input  logic                engine_done_i,
    output logic                start_o,
    output logic                true_done_o,
    output logic                busy_o,
    output logic                is_critical_o,
    output logic                full_context_o,
    output logic [CW-1:0]       pointer_context_o,
    output logic [CW-1:0]       running_context_o,
    output logic [ID_WIDTH-1:0] lock_owner_o,
    output logic [CW:0]         n_pending_o
);

    typedef enum logic [1:0] {IDLE, START, RUN, RETIRE} state_e;

    localparam logic [CW:0] CNT_FULL    = N_CONTEXT[CW:0];
    localparam bit          TIMEOUT_EN  = (LOCK_TIMEOUT != 0);
    // Last counter value before the lock is dropped; unused when the timeout is off.
    localparam logic [7:0]  TIMEOUT_TOP = TIMEOUT_EN ? 8'(LOCK_TIMEOUT - 1) : 8'd0;

    state_e                state_q, state_d;
    logic [CW:0]           cnt_q, cnt_d;
    logic [CW-1:0]         wptr_q, wptr_d;
    logic [CW-1:0]         rptr_q, rptr_d;
    logic                  lock_q, lock_d;
    logic [ID_WIDTH-1:0]   owner_q, owner_d;
    logic [7:0]            tcnt_q, tcnt_d;

    logic full;
    logic trig_acc;
    logic ts_acc;
    logic retire;
    logic timeout_hit;

    assign full        = (cnt_q == CNT_FULL);
    // A trigger needs the lock and must come from its holder; a testset can
    // only win when the lock is free, so both can never be accepted together.
    assign trig_acc    = trigger_i & lock_q & (trigger_src_i == owner_q);
    assign ts_acc      = testset_i & ~lock_q & ~full;
    assign retire      = (state_q == RETIRE);
    assign timeout_hit = TIMEOUT_EN & lock_q & ~trig_acc & (tcnt_q == TIMEOUT_TOP);

    // Occupancy counter and ring pointers: commit pushes, retire pops.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        cnt_d  = cnt_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        unique case ({trig_acc, retire})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (trig_acc) wptr_d = wptr_q + 1'b1;
        if (retire)   rptr_d = rptr_q + 1'b1;
    end

    // Offload lock: acquire, release on commit, optional idle timeout.
    always_comb begin
        lock_d  = lock_q;
        owner_d = owner_q;
        tcnt_d  = tcnt_q;
        if (trig_acc) begin
            lock_d = 1'b0;
        end else if (ts_acc) begin
            lock_d  = 1'b1;
            owner_d = testset_src_i;
            tcnt_d  = 8'd0;
        end else if (lock_q) begin
            tcnt_d = tcnt_q + 8'd1;
            if (timeout_hit) lock_d = 1'b0;
        end
    end

    // Job FSM next state and its pulse outputs.
    always_comb begin
        state_d     = state_q;
        start_o     = 1'b0;
        true_done_o = 1'b0;
        unique case (state_q)
            IDLE:    if (cnt_q != '0) state_d = START;
            START: begin
                start_o = 1'b1;
                state_d = RUN;
            end
            RUN:     if (engine_done_i) state_d = RETIRE;
            RETIRE: begin
                true_done_o = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; soft clear behaves exactly like reset.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i || clear_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            lock_q  <= 1'b0;
            owner_q <= '0;
            tcnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            lock_q  <= lock_d;
            owner_q <= owner_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign busy_o            = (cnt_q != '0) || (state_q != IDLE);
    assign is_critical_o     = lock_q;
    assign full_context_o    = full;
    assign pointer_context_o = wptr_q;
    assign running_context_o = rptr_q;
    assign lock_owner_o      = owner_q;
    assign n_pending_o       = cnt_q;

endmodule

// File: tb/tb_hwpe_ctrl_context_scheduler.sv
// Scoreboard bench: two scheduler instances (2 contexts without timeout,
// 4 contexts with LOCK_TIMEOUT=4) share one stimulus stream. A job-level
// reference model predicts every cycle's outputs into a queue; a monitor
// pops and compares on the falling edge.
module tb_hwpe_ctrl_context_scheduler;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        clear_i = 1'b0;
    logic        testset_i = 1'b0;
    logic [15:0] testset_src_i = '0;
    logic        trigger_i = 1'b0;
    logic [15:0] trigger_src_i = '0;
    logic        engine_done_i = 1'b0;

    logic        a_start, a_done, a_busy, a_crit, a_full;
    logic [0:0]  a_ptr, a_run;
    logic [1:0]  a_npend;
    logic [15:0] a_owner;

    logic        b_start, b_done, b_busy, b_crit, b_full;
    logic [1:0]  b_ptr, b_run;
    logic [2:0]  b_npend;
    logic [15:0] b_owner;

    always #5 clk = ~clk;

    hwpe_ctrl_context_scheduler #(.N_CONTEXT(2), .ID_WIDTH(16), .LOCK_TIMEOUT(0)) dut_a (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
        .testset_i(testset_i), .testset_src_i(testset_src_i),
        .trigger_i(trigger_i), .trigger_src_i(trigger_src_i),
        .engine_done_i(engine_done_i),
        .start_o(a_start), .true_done_o(a_done), .busy_o(a_busy),
        .is_critical_o(a_crit), .full_context_o(a_full),
        .pointer_context_o(a_ptr), .running_context_o(a_run),
        .lock_owner_o(a_owner), .n_pending_o(a_npend)
    );

    hwpe_ctrl_context_scheduler #(.N_CONTEXT(4), .ID_WIDTH(16), .LOCK_TIMEOUT(4)) dut_b (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i),
        .testset_i(testset_i), .testset_src_i(testset_src_i),
        .trigger_i(trigger_i), .trigger_src_i(trigger_src_i),
        .engine_done_i(engine_done_i),
        .start_o(b_start), .true_done_o(b_done), .busy_o(b_busy),
        .is_critical_o(b_crit), .full_context_o(b_full),
        .pointer_context_o(b_ptr), .running_context_o(b_run),
        .lock_owner_o(b_owner), .n_pending_o(b_npend)
    );

    // Job lifecycle of the head job: waiting, starting, running, retiring.
    localparam int PH_WAIT   = 0;
    localparam int PH_START  = 1;
    localparam int PH_RUN    = 2;
    localparam int PH_RETIRE = 3;

    // pend = jobs queued, commits/retires = total jobs ever committed/retired
    // since the last reset; pointers are those totals modulo the ring size.
    typedef struct {
        int pend;
        int commits;
        int retires;
        int lock;
        int owner;
        int age;
        int phase;
    } mdl_t;

    typedef struct {
        int start;
        int done;
        int busy;
        int full;
        int crit;
        int ptr;
        int run;
        int npend;
        int owner;
    } obs_t;

    typedef struct {
        obs_t a;
        obs_t b;
        int   cyc;
    } snap_t;

    snap_t sb_q[$];
    mdl_t  ma = '{default: 0};
    mdl_t  mb = '{default: 0};
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;

    function automatic obs_t predict(input mdl_t m, input int n);
        obs_t o;
        o.start = (m.phase == PH_START) ? 1 : 0;
        o.done  = (m.phase == PH_RETIRE) ? 1 : 0;
        o.busy  = (m.pend != 0 || m.phase != PH_WAIT) ? 1 : 0;
        o.full  = (m.pend == n) ? 1 : 0;
        o.crit  = m.lock;
        o.ptr   = m.commits % n;
        o.run   = m.retires % n;
        o.npend = m.pend;
        o.owner = m.owner;
        return o;
    endfunction

    function automatic mdl_t step(input mdl_t m, input int n, input int lt,
                                  input bit rs, input bit cl, input bit ts, input int tss,
                                  input bit tr, input int trs, input bit dn);
        mdl_t r;
        bit   commit;
        bit   grab;
        bit   leave;
        r = m;
        if (rs || cl) begin
            r = '{default: 0};
            return r;
        end
        commit = tr && (m.lock == 1) && (trs == m.owner);
        grab   = ts && (m.lock == 0) && (m.pend < n);
        leave  = (m.phase == PH_RETIRE);
        r.pend    = m.pend + (commit ? 1 : 0) - (leave ? 1 : 0);
        r.commits = m.commits + (commit ? 1 : 0);
        r.retires = m.retires + (leave ? 1 : 0);
        case (m.phase)
            PH_WAIT:  if (m.pend > 0) r.phase = PH_START;
            PH_START: r.phase = PH_RUN;
            PH_RUN:   if (dn) r.phase = PH_RETIRE;
            default:  r.phase = PH_WAIT;
        endcase
        if (commit) begin
            r.lock = 0;
        end else if (grab) begin
            r.lock  = 1;
            r.owner = tss;
            r.age   = 0;
        end else if (m.lock == 1) begin
            if (lt > 0 && m.age == lt - 1) r.lock = 0;
            r.age = m.age + 1;
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp, input int c);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, c, act, exp);
        end
    endtask

    task automatic cmp_obs(input string tag, input obs_t act, input obs_t exp, input int c);
        check({tag, ".start_o"},           act.start, exp.start, c);
        check({tag, ".true_done_o"},       act.done,  exp.done,  c);
        check({tag, ".busy_o"},            act.busy,  exp.busy,  c);
        check({tag, ".full_context_o"},    act.full,  exp.full,  c);
        check({tag, ".is_critical_o"},     act.crit,  exp.crit,  c);
        check({tag, ".pointer_context_o"}, act.ptr,   exp.ptr,   c);
        check({tag, ".running_context_o"}, act.run,   exp.run,   c);
        check({tag, ".n_pending_o"},       act.npend, exp.npend, c);
        check({tag, ".lock_owner_o"},      act.owner, exp.owner, c);
    endtask

    // Monitor: compare the DUT outputs with the oldest prediction each cycle.
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            snap_t s;
            obs_t  aa;
            obs_t  ab;
            s = sb_q.pop_front();
            aa = '{int'(a_start), int'(a_done), int'(a_busy), int'(a_full), int'(a_crit),
                   int'(a_ptr), int'(a_run), int'(a_npend), int'(a_owner)};
            ab = '{int'(b_start), int'(b_done), int'(b_busy), int'(b_full), int'(b_crit),
                   int'(b_ptr), int'(b_run), int'(b_npend), int'(b_owner)};
            cmp_obs("n2", aa, s.a, s.cyc);
            cmp_obs("n4_to4", ab, s.b, s.cyc);
        end
    end

    // One cycle of stimulus: record what the outputs must be now, then
    // advance the model with the inputs applied for the next edge.
    task automatic drv(input bit rs, input bit cl, input bit ts, input int tss,
                       input bit tr, input int trs, input bit dn);
        snap_t s;
        @(posedge clk);
        #1;
        cyc++;
        s.a   = predict(ma, 2);
        s.b   = predict(mb, 4);
        s.cyc = cyc;
        sb_q.push_back(s);
        ma = step(ma, 2, 0, rs, cl, ts, tss, tr, trs, dn);
        mb = step(mb, 4, 4, rs, cl, ts, tss, tr, trs, dn);
        rst_i         = rs;
        clear_i       = cl;
        testset_i     = ts;
        testset_src_i = 16'(tss);
        trigger_i     = tr;
        trigger_src_i = 16'(trs);
        engine_done_i = dn;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) drv(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tset(input int src);
        drv(0, 0, 1, src, 0, 0, 0);
    endtask

    task automatic trig(input int src);
        drv(0, 0, 0, 0, 1, src, 0);
    endtask

    task automatic done_pulse();
        drv(0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic clr();
        drv(0, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d actual=running expected=finished", cyc);
        $fatal(1);
    end

    initial begin
        // Reset held through the first edges; the first snapshot is the reset state.
        drv(1, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Basic job: lock by 3, commit by 3, one engine completion.
        tset(3);
        trig(3);
        idle(2);
        done_pulse();
        idle(3);

        // Fill the 2-context ring; the third testset must be refused there.
        tset(1);
        trig(1);
        tset(2);
        trig(2);
        tset(9);
        idle(2);
        done_pulse();
        idle(3);

        // Foreign trigger, then the owner's trigger.
        tset(5);
        trig(7);
        idle(2);
        trig(5);
        idle(3);

        // Clear while a job runs with two contexts occupied.
        clr();
        idle(2);

        // Retire and commit in the same cycle.
        tset(4);
        trig(4);
        idle(2);
        drv(0, 0, 1, 4, 0, 0, 1);
        trig(4);
        idle(4);
        done_pulse();
        idle(3);

        // Lock left unused: times out on the LOCK_TIMEOUT=4 instance only.
        tset(6);
        idle(7);
        trig(6);
        clr();

        // Jobs after the clear, checking pointer wrap.
        for (int j = 0; j < 5; j++) begin
            tset(j);
            trig(j);
            idle(2);
            done_pulse();
            idle(2);
        end

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit rs, cl, ts, tr, dn;
            int tss, trs;
            rs  = ($urandom_range(0, 299) == 0);
            cl  = ($urandom_range(0, 79) == 0);
            ts  = ($urandom_range(0, 2) == 0);
            tss = $urandom_range(0, 3);
            tr  = ($urandom_range(0, 2) == 0);
            trs = $urandom_range(0, 3);
            dn  = ($urandom_range(0, 3) == 0);
            drv(rs, cl, ts, tss, tr, trs, dn);
        end
        idle(2);

        repeat (4) @(posedge clk);
        check("scoreboard_drained", sb_q.size(), 0, cyc);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
